// File: rtl/trees_burst_driver.sv
// trees_burst_driver: loads a feature burst into the tree accelerator, starts it, streams predictions back.
// Optional done watchdog: define TREES_DRV_TIMEOUT_EN.
module trees_burst_driver #(
  parameter  int N_FEATURE   = 32,
  parameter  int MAX_BURST   = 5000,
  parameter  int TIMEOUT_CYC = 2**20,
  localparam int BL          = $clog2(MAX_BURST),
  localparam int FA          = $clog2(MAX_BURST*N_FEATURE)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic [BL-1:0] i_cmd_burst_len,
  output logic          o_cmd_err,
  input  logic          i_s_feat_valid,
  output logic          o_s_feat_ready,
  input  logic [63:0]   i_s_feat_data,
  output logic          o_m_pred_valid,
  input  logic          i_m_pred_ready,
  output logic [63:0]   o_m_pred_data,
  output logic          o_m_pred_last,
  output logic          o_busy,
  output logic          o_acc_load_features,
  output logic [FA-1:0] o_acc_feature_addr,
  output logic [63:0]   o_acc_features,
  output logic [BL-1:0] o_acc_burst_len,
  output logic          o_acc_start,
  input  logic          i_acc_done,
  output logic [BL-1:0] o_acc_prediction_addr,
  input  logic [63:0]   i_acc_prediction
);
  localparam int WPS = N_FEATURE/2;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_READ} state_t;

  state_t        r_state, w_next;
  logic [BL-1:0] r_len;
  logic [FA-1:0] r_waddr, r_last_waddr;
  logic [BL-1:0] r_ridx, r_last_ridx;
  logic          r_rd_done;
  logic          r_cmd_err;
  logic          r_pred_valid, r_pred_last;
  logic [63:0]   r_pred_data;

  logic          w_cmd_bad, w_feat_hs, w_out_hs, w_load_out, w_timeout;
  logic [BL:0]   w_len_p7;
  logic [63:0]   w_pred_word;

  // Lanes at or above len%8 in the final word hold stale accelerator data.
  function automatic logic [63:0] f_mask(input logic [63:0] d, input logic [2:0] rem);
    f_mask = d;
    for (int k = 0; k < 8; k++)
      if (rem != 3'd0 && k >= int'(rem)) f_mask[8*k +: 8] = 8'h00;
  endfunction

  assign w_cmd_bad   = (i_cmd_burst_len == '0) || (i_cmd_burst_len > BL'(MAX_BURST));
  assign w_feat_hs   = (r_state == S_LOAD) && i_s_feat_valid;
  assign w_out_hs    = r_pred_valid && i_m_pred_ready;
  assign w_load_out  = (r_state == S_READ) && !r_rd_done && (!r_pred_valid || i_m_pred_ready);
  assign w_len_p7    = {1'b0, i_cmd_burst_len} + (BL+1)'(7);
  assign w_pred_word = (r_ridx == r_last_ridx) ? f_mask(i_acc_prediction, r_len[2:0])
                                               : i_acc_prediction;

`ifdef TREES_DRV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC+1);
  logic [TW-1:0] r_tcnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || r_state != S_WAIT) r_tcnt <= '0;
    else                            r_tcnt <= r_tcnt + TW'(1);
  end

  assign w_timeout = (r_state == S_WAIT) && !i_acc_done && (r_tcnt == TW'(TIMEOUT_CYC-1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_cmd_valid && !w_cmd_bad) w_next = S_LOAD;
      S_LOAD:  if (w_feat_hs && r_waddr == r_last_waddr) w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT:  if (i_acc_done) w_next = S_READ;
               else if (w_timeout) w_next = S_IDLE;
      S_READ:  if (w_out_hs && r_pred_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_cmd_ready           = (r_state == S_IDLE);
    o_busy                = (r_state != S_IDLE);
    o_s_feat_ready        = (r_state == S_LOAD);
    o_acc_load_features   = w_feat_hs;
    o_acc_feature_addr    = '0;
    o_acc_features        = '0;
    o_acc_start           = (r_state == S_START);
    o_acc_burst_len       = '0;
    o_acc_prediction_addr = '0;
    if (r_state == S_LOAD) begin
      o_acc_feature_addr = r_waddr;
      o_acc_features     = i_s_feat_data;
    end
    if (r_state == S_START || r_state == S_WAIT || r_state == S_READ)
      o_acc_burst_len = r_len;
    if (r_state == S_READ)
      o_acc_prediction_addr = r_ridx;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len        <= '0;
      r_waddr      <= '0;
      r_last_waddr <= '0;
      r_ridx       <= '0;
      r_last_ridx  <= '0;
      r_rd_done    <= 1'b0;
      r_cmd_err    <= 1'b0;
      r_pred_valid <= 1'b0;
      r_pred_last  <= 1'b0;
      r_pred_data  <= '0;
    end else begin
      r_cmd_err <= ((r_state == S_IDLE) && i_cmd_valid && w_cmd_bad) || w_timeout;
      if (r_state == S_IDLE && i_cmd_valid) begin
        r_len        <= i_cmd_burst_len;
        r_waddr      <= '0;
        r_last_waddr <= FA'(i_cmd_burst_len) * FA'(WPS) - FA'(1);
        r_last_ridx  <= BL'((w_len_p7 >> 3) - (BL+1)'(1));
      end
      if (w_feat_hs) r_waddr <= r_waddr + FA'(1);
      if (r_state == S_WAIT) begin
        r_ridx    <= '0;
        r_rd_done <= 1'b0;
      end
      // Read data is combinational on the address, so one output register gives full rate.
      if (w_load_out) begin
        r_pred_data  <= w_pred_word;
        r_pred_valid <= 1'b1;
        r_pred_last  <= (r_ridx == r_last_ridx);
        if (r_ridx == r_last_ridx) r_rd_done <= 1'b1;
        else                       r_ridx    <= r_ridx + BL'(1);
      end else if (w_out_hs) begin
        r_pred_valid <= 1'b0;
        r_pred_last  <= 1'b0;
      end
    end
  end

  assign o_cmd_err      = r_cmd_err;
  assign o_m_pred_valid = r_pred_valid;
  assign o_m_pred_data  = r_pred_data;
  assign o_m_pred_last  = r_pred_last;

endmodule

// File: tb/tb_trees_burst_driver.sv
// Directed bench for trees_burst_driver: feature load, start/done handshake, masked prediction readback.
module tb_trees_burst_driver;
  localparam int BL = 13;
  localparam int FA = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_err;
  logic [BL-1:0] cmd_len;
  logic          s_valid, s_ready;
  logic [63:0]   s_data;
  logic          p_valid, p_ready, p_last;
  logic [63:0]   p_data;
  logic          busy, ld, start, done;
  logic [FA-1:0] faddr;
  logic [63:0]   fdata;
  logic [BL-1:0] blen, paddr;
  logic [63:0]   pred;
  logic [63:0]   pmem [0:3];
  logic [63:0]   exp_w [0:3];

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  assign pred = pmem[paddr[1:0]];

  trees_burst_driver dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_burst_len(cmd_len), .o_cmd_err(cmd_err),
    .i_s_feat_valid(s_valid), .o_s_feat_ready(s_ready), .i_s_feat_data(s_data),
    .o_m_pred_valid(p_valid), .i_m_pred_ready(p_ready), .o_m_pred_data(p_data), .o_m_pred_last(p_last),
    .o_busy(busy), .o_acc_load_features(ld), .o_acc_feature_addr(faddr), .o_acc_features(fdata),
    .o_acc_burst_len(blen), .o_acc_start(start), .i_acc_done(done),
    .o_acc_prediction_addr(paddr), .i_acc_prediction(pred)
  );

  function automatic logic [63:0] fdat(input int w);
    return {32'hA5A5_0000 ^ 32'(w), ~32'(w)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Monitor: cumulative counters, bursts compare against snapshots.
  int wr_cnt = 0, addr_bad = 0, data_bad = 0, starts = 0, err_cnt = 0;
  int rdy_cyc = 0, busy_cyc = 0, stall_bad = 0;
  logic [FA-1:0] last_addr = '0;
  logic [BL-1:0] start_len = '0;
  logic [64:0]   rxq [$];
  logic          prev_stall = 1'b0;
  logic [63:0]   prev_data = '0;

  always @(posedge clk) begin
    if (ld) begin
      if (faddr != '0 && faddr != last_addr + FA'(1)) addr_bad++;
      if (fdata != fdat(int'(faddr))) data_bad++;
      last_addr = faddr;
      wr_cnt++;
    end
    if (start) begin starts++; start_len = blen; end
    if (cmd_err) err_cnt++;
    if (s_ready) rdy_cyc++;
    if (busy) busy_cyc++;
    if (prev_stall && (!p_valid || p_data != prev_data)) stall_bad++;
    prev_stall = p_valid && !p_ready;
    prev_data  = p_data;
    if (p_valid && p_ready) rxq.push_back({p_last, p_data});
  end

  task automatic feed(input int n, input bit rnd);
    for (int w = 0; w < n; w++) begin
      if (rnd) while ($urandom_range(0, 3) == 0) @(negedge clk);
      s_valid = 1'b1;
      s_data  = fdat(w);
      for (int g = 0; g < 50 && !s_ready; g++) @(negedge clk);
      @(negedge clk);
      s_valid = 1'b0;
    end
  endtask

  task automatic send_cmd(input int len);
    cmd_valid = 1'b1;
    cmd_len   = BL'(len);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_burst(input int len, input bit rnd);
    int wr0, ab0, db0, st0, er0, sb0, rx0, nw, g;
    wr0 = wr_cnt; ab0 = addr_bad; db0 = data_bad; st0 = starts;
    er0 = err_cnt; sb0 = stall_bad; rx0 = rxq.size();
    nw  = (len + 7) / 8;
    send_cmd(len);
    feed(len*16, rnd);
    g = 0;
    while (starts == st0 && g < 20) begin @(negedge clk); g++; end
    chk("start_seen", 64'(starts - st0), 64'd1);
    chk("acc_blen", 64'(start_len), 64'(len));
    repeat (3) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    g = 0;
    while (rxq.size() - rx0 < nw && g < 400) begin
      p_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      g++;
    end
    p_ready = 1'b1;
    repeat (3) @(negedge clk);
    p_ready = 1'b0;
    chk("n_writes", 64'(wr_cnt - wr0), 64'(len*16));
    chk("last_faddr", 64'(last_addr), 64'(len*16 - 1));
    chk("faddr_contig", 64'(addr_bad - ab0), 64'd0);
    chk("fdata", 64'(data_bad - db0), 64'd0);
    chk("n_starts", 64'(starts - st0), 64'd1);
    chk("no_err", 64'(err_cnt - er0), 64'd0);
    chk("stall_stable", 64'(stall_bad - sb0), 64'd0);
    chk("n_words", 64'(rxq.size() - rx0), 64'(nw));
    for (int i = 0; i < nw && rx0 + i < rxq.size(); i++) begin
      chk($sformatf("pdata%0d", i), rxq[rx0+i][63:0], exp_w[i]);
      chk($sformatf("plast%0d", i), 64'(rxq[rx0+i][64]), 64'(i == nw-1));
    end
    chk("busy_end", 64'(busy), 64'd0);
  endtask

  initial begin
    int er0, rc0, bc0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; s_valid = 1'b0; s_data = '0;
    p_ready = 1'b0; done = 1'b0;
    for (int i = 0; i < 4; i++) begin pmem[i] = '0; exp_w[i] = '0; end
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_p_valid", 64'(p_valid), 64'd0);
    chk("rst_err", 64'(cmd_err), 64'd0);
    chk("rst_start", 64'(start), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // len=1: only byte 0 survives the mask
    pmem[0] = 64'hFFFF_FFFF_FFFF_FF05; exp_w[0] = 64'h0000_0000_0000_0005;
    run_burst(1, 1'b0);

    // len=8: full word unmasked
    pmem[0] = 64'h8877_6655_4433_2211; exp_w[0] = 64'h8877_6655_4433_2211;
    run_burst(8, 1'b0);

    // len=10: second word keeps bytes 0..1
    pmem[0] = 64'h0123_4567_89AB_CDEF; exp_w[0] = 64'h0123_4567_89AB_CDEF;
    pmem[1] = 64'hFFFF_FFFF_FFFF_A1B2; exp_w[1] = 64'h0000_0000_0000_A1B2;
    run_burst(10, 1'b0);

    // rejected commands
    er0 = err_cnt; rc0 = rdy_cyc; bc0 = busy_cyc;
    send_cmd(0);
    repeat (2) @(negedge clk);
    send_cmd(5001);
    repeat (3) @(negedge clk);
    chk("rej_err", 64'(err_cnt - er0), 64'd2);
    chk("rej_s_ready", 64'(rdy_cyc - rc0), 64'd0);
    chk("rej_busy", 64'(busy_cyc - bc0), 64'd0);

    // len=17 with input gaps and output stalls
    pmem[0] = 64'h1111_2222_3333_4444; exp_w[0] = 64'h1111_2222_3333_4444;
    pmem[1] = 64'h5555_6666_7777_8888; exp_w[1] = 64'h5555_6666_7777_8888;
    pmem[2] = 64'hDEAD_BEEF_CAFE_0099; exp_w[2] = 64'h0000_0000_0000_0099;
    run_burst(17, 1'b1);

    // reset mid-LOAD once 7 words are in
    send_cmd(2);
    feed(7, 1'b0);
    rst = 1'b1; s_valid = 1'b1; s_data = fdat(7);
    @(negedge clk);
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
    chk("mid_rst_ld", 64'(ld), 64'd0);
    chk("mid_rst_start", 64'(start), 64'd0);
    rst = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    pmem[0] = 64'h0000_0000_0000_7A3C; exp_w[0] = 64'h0000_0000_0000_7A3C;
    pmem[0] = 64'hFFFF_FFFF_FFFF_7A3C;
    run_burst(2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
